// File: rtl/tpu_job_scheduler.sv
// Job queue and sequencer for the tpu matmul core: buffers descriptors,
// launches one job at a time, returns tagged completions, and watches for a
// hung core.
module tpu_job_scheduler #(
    parameter int unsigned AW    = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned TO_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [TAG_W-1:0]         req_tag_i,
    input  logic [AW-1:0]            req_m_i,
    input  logic [AW-1:0]            req_k_i,
    input  logic [AW-1:0]            req_n_i,
    input  logic [AW-1:0]            req_base_a_i,
    input  logic [AW-1:0]            req_base_b_i,
    input  logic [AW-1:0]            req_base_p_i,
    output logic                     tpu_start_o,
    input  logic                     tpu_valid_i,
    output logic [AW-1:0]            tpu_m_o,
    output logic [AW-1:0]            tpu_k_o,
    output logic [AW-1:0]            tpu_n_o,
    output logic [AW-1:0]            tpu_base_a_o,
    output logic [AW-1:0]            tpu_base_b_o,
    output logic [AW-1:0]            tpu_base_p_o,
    output logic                     done_valid_o,
    input  logic                     done_ready_i,
    output logic [TAG_W-1:0]         done_tag_o,
    output logic                     done_err_o,
    input  logic [TO_W-1:0]          timeout_i,
    output logic                     busy_o,
    output logic                     hang_o,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic [15:0]              jobs_done_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DONE_W = 16;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [AW-1:0]    m;
        logic [AW-1:0]    k;
        logic [AW-1:0]    n;
        logic [AW-1:0]    base_a;
        logic [AW-1:0]    base_b;
        logic [AW-1:0]    base_p;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        REPORT = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    desc_t               fifo_mem [DEPTH];
    desc_t               req_desc, head, job_q;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                full, empty, push, pop;
    logic                head_zero;
    logic                err_q, err_load, err_val;
    logic                hang_q, set_hang;
    logic                wd_clr, wd_inc, wd_expired;
    logic [TO_W-1:0]     wd_cnt;
    logic                done_hs;
    logic [DONE_W-1:0]   jobs_done_q;

    assign req_desc = '{tag: req_tag_i, m: req_m_i, k: req_k_i, n: req_n_i,
                        base_a: req_base_a_i, base_b: req_base_b_i,
                        base_p: req_base_p_i};

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign push        = req_valid_i & ~full;
    assign req_ready_o = ~full;
    assign head        = fifo_mem[rd_ptr];
    assign head_zero   = (head.m == '0) || (head.k == '0) || (head.n == '0);
    assign wd_expired  = (timeout_i != '0) && (wd_cnt == timeout_i - TO_W'(1));

    // Descriptor storage; contents need no reset since occupancy gates reads
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_desc;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and datapath controls
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        err_load = 1'b0;
        err_val  = 1'b0;
        set_hang = 1'b0;
        wd_clr   = 1'b0;
        wd_inc   = 1'b0;
        done_hs  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_zero) begin
                        err_load = 1'b1;
                        err_val  = 1'b1;
                        state_d  = REPORT;
                    end else begin
                        state_d  = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                wd_clr  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                wd_inc = 1'b1;
                // A completion in the expiry cycle still counts as success
                if (tpu_valid_i) begin
                    err_load = 1'b1;
                    err_val  = 1'b0;
                    state_d  = REPORT;
                end else if (wd_expired) begin
                    err_load = 1'b1;
                    err_val  = 1'b1;
                    set_hang = 1'b1;
                    state_d  = REPORT;
                end
            end
            REPORT: begin
                if (done_ready_i) begin
                    done_hs = 1'b1;
                    state_d = hang_q ? HALT : IDLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Current job registers; change only on a pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            job_q <= '0;
        end else if (pop) begin
            job_q <= head;
        end
    end

    // Completion status, sticky hang flag and completion counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q       <= 1'b0;
            hang_q      <= 1'b0;
            jobs_done_q <= '0;
        end else begin
            if (err_load) begin
                err_q <= err_val;
            end
            if (set_hang) begin
                hang_q <= 1'b1;
            end
            if (done_hs) begin
                jobs_done_q <= jobs_done_q + DONE_W'(1);
            end
        end
    end

    // Watchdog counter: cleared at launch, counts RUN cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt <= '0;
        end else if (wd_clr) begin
            wd_cnt <= '0;
        end else if (wd_inc) begin
            wd_cnt <= wd_cnt + TO_W'(1);
        end
    end

    assign tpu_start_o  = (state_q == LAUNCH);
    assign done_valid_o = (state_q == REPORT);
    assign busy_o       = (state_q != IDLE);
    assign hang_o       = hang_q;
    assign done_err_o   = err_q;
    assign done_tag_o   = job_q.tag;
    assign tpu_m_o      = job_q.m;
    assign tpu_k_o      = job_q.k;
    assign tpu_n_o      = job_q.n;
    assign tpu_base_a_o = job_q.base_a;
    assign tpu_base_b_o = job_q.base_b;
    assign tpu_base_p_o = job_q.base_p;
    assign pending_o    = count;
    assign jobs_done_o  = jobs_done_q;

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Randomised bench for tpu_job_scheduler: a transaction-level scoreboard
// predicts launch order, completion tags/errors and handshake latencies.
module tb_tpu_job_scheduler;

    typedef struct packed {
        logic [3:0]  tag;
        logic [15:0] m;
        logic [15:0] k;
        logic [15:0] n;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
    } desc_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_tag_i;
    logic [15:0] req_m_i, req_k_i, req_n_i;
    logic [15:0] req_base_a_i, req_base_b_i, req_base_p_i;
    logic        tpu_start_o;
    logic        tpu_valid_i;
    logic [15:0] tpu_m_o, tpu_k_o, tpu_n_o;
    logic [15:0] tpu_base_a_o, tpu_base_b_o, tpu_base_p_o;
    logic        done_valid_o;
    logic        done_ready_i;
    logic [3:0]  done_tag_o;
    logic        done_err_o;
    logic [15:0] timeout_i;
    logic        busy_o;
    logic        hang_o;
    logic [2:0]  pending_o;
    logic [15:0] jobs_done_o;

    // Bench state: stimulus queue, expected-job queue and core model
    desc_t req_q[$];
    desc_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    model_done = 0;
    int    n_starts = 0;
    int    start_cyc = 0;
    int    valid_cyc = -1;
    int    exp_evt_cyc = -1;
    int    cur_t = 0;
    int    cd = 0;
    int    core_lat = 10;
    bit    lat_rand = 1'b0;
    bit    lat_never = 1'b0;
    bit    ready_rand = 1'b0;
    bit    ready_lvl = 1'b1;
    bit    inflight = 1'b0;
    bit    halted = 1'b0;
    bit    cur_to = 1'b0;
    bit    done_seen = 1'b0;
    logic  core_valid = 1'b0;
    logic  stray_valid = 1'b0;

    assign tpu_valid_i = core_valid | stray_valid;

    tpu_job_scheduler #(.AW(16), .DEPTH(4), .TAG_W(4), .TO_W(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_tag_i(req_tag_i), .req_m_i(req_m_i), .req_k_i(req_k_i),
        .req_n_i(req_n_i), .req_base_a_i(req_base_a_i),
        .req_base_b_i(req_base_b_i), .req_base_p_i(req_base_p_i),
        .tpu_start_o(tpu_start_o), .tpu_valid_i(tpu_valid_i),
        .tpu_m_o(tpu_m_o), .tpu_k_o(tpu_k_o), .tpu_n_o(tpu_n_o),
        .tpu_base_a_o(tpu_base_a_o), .tpu_base_b_o(tpu_base_b_o),
        .tpu_base_p_o(tpu_base_p_o),
        .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_tag_o(done_tag_o), .done_err_o(done_err_o),
        .timeout_i(timeout_i), .busy_o(busy_o), .hang_o(hang_o),
        .pending_o(pending_o), .jobs_done_o(jobs_done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_zero(input desc_t d);
        return (d.m == 16'd0) || (d.k == 16'd0) || (d.n == 16'd0);
    endfunction

    function automatic desc_t rand_desc(input int tag, input bit zero);
        desc_t d;
        d.tag = 4'(tag);
        d.m   = 16'($urandom_range(1, 64));
        d.k   = 16'($urandom_range(1, 64));
        d.n   = 16'($urandom_range(1, 64));
        d.a   = 16'($urandom);
        d.b   = 16'($urandom);
        d.p   = 16'($urandom);
        if (zero) begin
            case ($urandom_range(0, 2))
                0:       d.m = 16'd0;
                1:       d.k = 16'd0;
                default: d.n = 16'd0;
            endcase
        end
        return d;
    endfunction

    function automatic logic [127:0] out_desc();
        return 128'({tpu_m_o, tpu_k_o, tpu_n_o, tpu_base_a_o, tpu_base_b_o, tpu_base_p_o});
    endfunction

    function automatic logic [127:0] exp_desc(input desc_t d);
        return 128'({d.m, d.k, d.n, d.a, d.b, d.p});
    endfunction

    task automatic check_reset_vals(input string p);
        check({p, "_ready"},      128'(req_ready_o),  128'(1));
        check({p, "_start"},      128'(tpu_start_o),  128'(0));
        check({p, "_done_valid"}, 128'(done_valid_o), 128'(0));
        check({p, "_done_tag"},   128'(done_tag_o),   128'(0));
        check({p, "_done_err"},   128'(done_err_o),   128'(0));
        check({p, "_busy"},       128'(busy_o),       128'(0));
        check({p, "_hang"},       128'(hang_o),       128'(0));
        check({p, "_pending"},    128'(pending_o),    128'(0));
        check({p, "_jobs_done"},  128'(jobs_done_o),  128'(0));
        check({p, "_desc"},       out_desc(),         128'(0));
    endtask

    task automatic wait_done(input int target, input int budget);
        int i = 0;
        while (model_done < target && i < budget) begin
            @(negedge clk_i);
            i++;
        end
        check("wait_done", 128'(model_done), 128'(target));
    endtask

    task automatic wait_start(input int target, input int budget);
        int i = 0;
        while (n_starts < target && i < budget) begin
            @(negedge clk_i);
            i++;
        end
        check("wait_start", 128'(n_starts), 128'(target));
    endtask

    // Driver, core model and scoreboard, evaluated mid-cycle
    always @(negedge clk_i) begin : mon
        desc_t h;
        bit    z;
        int    lat;
        if (!rst_ni) begin
            req_valid_i = 1'b0;
            core_valid  = 1'b0;
            cd          = 0;
        end else begin
            // Core model: one-cycle valid pulse 'lat' cycles after the start
            core_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    core_valid = 1'b1;
                    valid_cyc  = cyc;
                end
            end
            if (tpu_start_o) begin
                check("start_when_free", 128'(inflight), 128'(0));
                check("start_after_hang", 128'(halted), 128'(0));
                check("start_queue_nonempty", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    h = exp_q[0];
                    check("start_job_nonzero", 128'(is_zero(h)), 128'(0));
                    check("start_desc", out_desc(), exp_desc(h));
                end
                if (exp_evt_cyc >= 0) check("start_latency", 128'(cyc), 128'(exp_evt_cyc));
                exp_evt_cyc = -1;
                lat       = lat_rand ? int'($urandom_range(1, 20)) : core_lat;
                cur_t     = int'(timeout_i);
                cur_to    = (cur_t != 0) && (lat_never || lat > cur_t);
                inflight  = 1'b1;
                start_cyc = cyc;
                valid_cyc = -1;
                if (!lat_never) cd = lat;
                n_starts++;
            end
            // Request driver
            if (req_q.size() != 0) begin
                h = req_q[0];
                req_valid_i  = 1'b1;
                req_tag_i    = h.tag;
                req_m_i      = h.m;
                req_k_i      = h.k;
                req_n_i      = h.n;
                req_base_a_i = h.a;
                req_base_b_i = h.b;
                req_base_p_i = h.p;
                if (req_ready_o) begin
                    if (exp_q.size() == 0 && !halted) exp_evt_cyc = cyc + 2;
                    exp_q.push_back(h);
                    void'(req_q.pop_front());
                end
            end else begin
                req_valid_i = 1'b0;
            end
            done_ready_i = ready_rand ? ($urandom_range(0, 3) != 0) : ready_lvl;
            // Completion checks
            if (done_valid_o) begin
                check("done_queue_nonempty", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    h = exp_q[0];
                    z = is_zero(h);
                    check("done_tag", 128'(done_tag_o), 128'(h.tag));
                    check("done_err", 128'(done_err_o), 128'(z ? 1'b1 : cur_to));
                    check("done_desc", out_desc(), exp_desc(h));
                    if (!done_seen) begin
                        done_seen = 1'b1;
                        if (z) begin
                            check("zero_no_start", 128'(inflight), 128'(0));
                            if (exp_evt_cyc >= 0) check("zero_latency", 128'(cyc), 128'(exp_evt_cyc));
                            exp_evt_cyc = -1;
                        end else begin
                            check("done_after_start", 128'(inflight), 128'(1));
                            if (cur_to) check("timeout_latency", 128'(cyc), 128'(start_cyc + cur_t + 1));
                            else        check("done_latency", 128'(cyc), 128'(valid_cyc + 1));
                        end
                    end
                    if (done_ready_i) begin
                        check("jobs_done", 128'(jobs_done_o), 128'(16'(model_done)));
                        check("hang_at_done", 128'(hang_o), 128'(!z && cur_to));
                        model_done++;
                        void'(exp_q.pop_front());
                        done_seen = 1'b0;
                        inflight  = 1'b0;
                        if (!z && cur_to) halted = 1'b1;
                        else if (exp_q.size() != 0) exp_evt_cyc = cyc + 2;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int    s0;
        int    base;
        int    i;
        desc_t d;
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_tag_i    = '0;
        req_m_i      = '0;
        req_k_i      = '0;
        req_n_i      = '0;
        req_base_a_i = '0;
        req_base_b_i = '0;
        req_base_p_i = '0;
        done_ready_i = 1'b0;
        timeout_i    = '0;
        repeat (2) @(negedge clk_i);
        #1;
        check_reset_vals("rst_init");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single 10x10x10 job, core answers 40 cycles after start
        core_lat = 40;
        d = rand_desc(3, 1'b0);
        d.m = 16'd10; d.k = 16'd10; d.n = 16'd10;
        req_q.push_back(d);
        wait_done(1, 200);
        @(negedge clk_i);
        check("t1_one_start", 128'(n_starts), 128'(1));
        check("t1_jobs_done", 128'(jobs_done_o), 128'(1));
        check("t1_idle", 128'(busy_o), 128'(0));

        // Fill the FIFO behind a running job
        core_lat = 30;
        base = model_done;
        req_q.push_back(rand_desc(1, 1'b0));
        wait_start(n_starts + 1, 50);
        for (int t = 2; t <= 6; t++) req_q.push_back(rand_desc(t, 1'b0));
        repeat (7) @(negedge clk_i);
        check("full_pending", 128'(pending_o), 128'(4));
        check("full_not_ready", 128'(req_ready_o), 128'(0));
        check("full_fifth_held", 128'(req_q.size()), 128'(1));
        wait_done(base + 6, 600);

        // Zero-K job between two valid jobs
        core_lat = 7;
        base = model_done;
        req_q.push_back(rand_desc(5, 1'b0));
        d = rand_desc(6, 1'b0);
        d.k = 16'd0;
        req_q.push_back(d);
        req_q.push_back(rand_desc(7, 1'b0));
        s0 = n_starts;
        wait_done(base + 3, 300);
        check("zero_job_starts", 128'(n_starts - s0), 128'(2));

        // Completion held by backpressure with another job queued
        ready_lvl = 1'b0;
        core_lat  = 5;
        base = model_done;
        req_q.push_back(rand_desc(8, 1'b0));
        req_q.push_back(rand_desc(9, 1'b0));
        i = 0;
        while (!done_valid_o && i < 100) begin
            @(negedge clk_i);
            i++;
        end
        check("hold_reached", 128'(done_valid_o), 128'(1));
        s0 = n_starts;
        repeat (10) @(negedge clk_i);
        check("hold_valid", 128'(done_valid_o), 128'(1));
        check("hold_no_launch", 128'(n_starts), 128'(s0));
        check("hold_pending", 128'(pending_o), 128'(1));
        ready_lvl = 1'b1;
        wait_done(base + 2, 200);

        // Valid in the same cycle the watchdog expires
        timeout_i = 16'd12;
        core_lat  = 12;
        base = model_done;
        req_q.push_back(rand_desc(10, 1'b0));
        wait_done(base + 1, 200);
        @(negedge clk_i);
        check("race_no_hang", 128'(hang_o), 128'(0));

        // Randomised traffic
        ready_rand = 1'b1;
        lat_rand   = 1'b1;
        timeout_i  = ($urandom_range(0, 1) != 0) ? 16'd25 : 16'd0;
        base = model_done;
        for (int j = 0; j < 24; j++) begin
            req_q.push_back(rand_desc(j, $urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) @(negedge clk_i);
        end
        wait_done(base + 24, 3000);
        ready_rand = 1'b0;
        lat_rand   = 1'b0;
        ready_lvl  = 1'b1;

        // Asynchronous reset while a job runs with two queued behind it
        timeout_i = '0;
        core_lat  = 60;
        for (int t = 11; t <= 13; t++) req_q.push_back(rand_desc(t, 1'b0));
        wait_start(n_starts + 1, 50);
        repeat (5) @(negedge clk_i);
        check("rst_queue_depth", 128'(exp_q.size()), 128'(3));
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_vals("rst_async");
        exp_q.delete();
        req_q.delete();
        inflight    = 1'b0;
        halted      = 1'b0;
        done_seen   = 1'b0;
        model_done  = 0;
        n_starts    = 0;
        exp_evt_cyc = -1;
        cd          = 0;
        @(negedge clk_i);
        rst_ni   = 1'b1;
        core_lat = 4;
        req_q.push_back(rand_desc(14, 1'b0));
        wait_done(1, 100);
        @(negedge clk_i);
        check("post_rst_jobs_done", 128'(jobs_done_o), 128'(1));

        // Hung core: watchdog timeout, then HALT ignores everything
        timeout_i = 16'd20;
        lat_never = 1'b1;
        base = model_done;
        req_q.push_back(rand_desc(15, 1'b0));
        wait_start(n_starts + 1, 50);
        req_q.push_back(rand_desc(1, 1'b0));
        req_q.push_back(rand_desc(2, 1'b0));
        wait_done(base + 1, 100);
        repeat (2) @(negedge clk_i);
        check("halt_hang", 128'(hang_o), 128'(1));
        check("halt_busy", 128'(busy_o), 128'(1));
        check("halt_pending", 128'(pending_o), 128'(2));
        s0 = n_starts;
        stray_valid = 1'b1;
        @(negedge clk_i);
        stray_valid = 1'b0;
        repeat (20) @(negedge clk_i);
        check("halt_no_start", 128'(n_starts), 128'(s0));
        check("halt_no_done", 128'(done_valid_o), 128'(0));
        req_q.push_back(rand_desc(3, 1'b0));
        req_q.push_back(rand_desc(4, 1'b0));
        repeat (6) @(negedge clk_i);
        check("halt_fifo_full", 128'(pending_o), 128'(4));
        check("halt_not_ready", 128'(req_ready_o), 128'(0));
        check("halt_jobs_done", 128'(jobs_done_o), 128'(base + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tpu_job_scheduler.md
# tpu_job_scheduler

Host-facing job queue and sequencer for the `tpu` matrix-multiply core. It buffers up to `DEPTH` matmul descriptors (M, K, N and base addresses A, B, P, plus a tag). It launches them one at a time on the core's `start_i`/`valid_o` handshake and returns a tagged completion record per job. A watchdog detects a hung core, and zero-dimension jobs are rejected without a launch. It sits between the host/AXI register front-end and the `tpu` top.

## Interface
- `AW`, 16, address/dimension width; instantiated with `` `ADDR_WIDTH``.
- `DEPTH`, 4, descriptor FIFO entries; power of two, ≥2.
- `TAG_W`, 4, job tag width.
- `TO_W`, 16, watchdog counter width.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: descriptor offered.
- `req_ready_o` out 1: FIFO can accept.
- `req_tag_i` in TAG_W: job tag.
- `req_m_i`, `req_k_i`, `req_n_i` in AW each: dimensions.
- `req_base_a_i`, `req_base_b_i`, `req_base_p_i` in AW each: base addresses.
- `tpu_start_o` out 1: one-cycle start pulse to `tpu.start_i`.
- `tpu_valid_i` in 1: from `tpu.valid_o`.
- `tpu_m_o`, `tpu_k_o`, `tpu_n_o`, `tpu_base_a_o`, `tpu_base_b_o`, `tpu_base_p_o` out AW each: descriptor of the current job.
- `done_valid_o` out 1: completion record valid.
- `done_ready_i` in 1: completion consumed.
- `done_tag_o` out TAG_W: tag of completed job.
- `done_err_o` out 1: 1 means the job was rejected (zero dimension) or timed out.
- `timeout_i` in TO_W: watchdog limit in cycles; 0 disables the watchdog.
- `busy_o` out 1: FSM not in IDLE.
- `hang_o` out 1: sticky; the core timed out.
- `pending_o` out $clog2(DEPTH)+1: FIFO occupancy.
- `jobs_done_o` out 16: completions handed off; wraps at 2^16.

## Operation
- FIFO:
  - Enqueue on `req_valid_i & req_ready_o`.
  - `req_ready_o = !full` (combinational). No enqueue when full, even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves occupancy unchanged.
- FSM states IDLE, LAUNCH, RUN, REPORT, HALT:
  - IDLE, FIFO not empty: pop the head into the job registers that drive `tpu_*_o`.
    - Any dimension == 0: go to REPORT with err=1.
    - Otherwise: go to LAUNCH.
  - LAUNCH: `tpu_start_o`=1 for exactly this cycle. Clear the watchdog. Go to RUN.
  - RUN: watchdog increments each cycle.
    - `tpu_valid_i`=1: go to REPORT with err=0.
    - Otherwise, `timeout_i`≠0 and count == `timeout_i`-1: go to REPORT with err=1 and set `hang_o`.
    - If both hold in the same cycle, `tpu_valid_i` wins (err=0, no hang).
  - REPORT: `done_valid_o`=1. Tag and err are held stable until `done_ready_i`. On the handshake, increment `jobs_done_o`, then go to HALT if `hang_o` is set, else IDLE.
  - HALT: terminal. No further pops or launches. FIFO still accepts until full. Only reset exits HALT.
- `tpu_valid_i` is ignored outside RUN. This covers stale levels and stray pulses after a timeout.
- `tpu_*_o` descriptor outputs are stable from LAUNCH through REPORT. They change only on a pop.
- Dimensions are passed unmodified. The core handles tiling.

## Timing
- Reset (async assert) values:
  - All outputs are 0 except `req_ready_o`=1.
  - FIFO is emptied, FSM goes to IDLE, counters and `hang_o` are cleared.
  - `tpu_start_o` drops immediately.
  - A job in flight is abandoned. The core is reset by the same `rst_ni`.
- Request accepted in cycle 0 with the FSM idle and FIFO empty: pop in cycle 1, `tpu_start_o` high in cycle 2, RUN from cycle 3.
- `tpu_valid_i` high in cycle r (in RUN): `done_valid_o` high from cycle r+1.
- Done handshake in cycle d: IDLE in d+1, next `tpu_start_o` in d+2 if the FIFO is non-empty.
- Zero-dimension job popped in cycle p: `done_valid_o` high in p+1. No start pulse is issued.
- Watchdog, `timeout_i`=T: the first RUN cycle is count 0, and the FSM leaves RUN after T cycles without valid.
- `pending_o` updates the cycle after each push or pop edge.

## Test plan
- Single job M=K=N=10 with tag 3, core model asserts valid 40 cycles after start -> exactly one `tpu_start_o` pulse in cycle 2; `done_tag_o`=3 and `done_err_o`=0 in the cycle after valid; `jobs_done_o`=1.
- Push 5 jobs back-to-back with DEPTH=4 -> `req_ready_o` drops after the 4th accept and recovers after the first pop. Tags complete in FIFO order. No start pulse is issued while the FSM is in RUN or REPORT.
- Job with K=0 between two valid jobs -> no start pulse for it; completion with err=1 and the correct tag; the neighbouring jobs are unaffected.
- `timeout_i`=20 and the core never asserts valid -> err=1 completion after 20 RUN cycles; `hang_o`=1; FSM holds HALT. A later stray `tpu_valid_i` and queued jobs cause no start.
- `done_ready_i` held low for 10 cycles -> `done_valid_o` and tag stay stable and no new launch occurs. `tpu_valid_i` arriving in the same cycle the watchdog expires -> err=0.
- Assert `rst_ni` during RUN with 2 jobs queued -> all outputs return to their reset values asynchronously; `pending_o`=0. After release, a new request launches normally.
